// File: rtl/alu_arbiter_if.sv
// Bundles the two requester ports, the two response buffers and the
// shared-ALU drive/return signals of alu_arbiter.
// slave  : arbiter side.
// master : environment side (requesters plus the shared ALU).
interface alu_arbiter_if;
  // requester 0
  logic        req0_valid;
  logic        req0_ready;
  logic [3:0]  req0_aluop;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  // requester 1
  logic        req1_valid;
  logic        req1_ready;
  logic [3:0]  req1_aluop;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  // response buffer 0
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic [31:0] rsp0_out;
  logic        rsp0_z;
  logic        rsp0_n;
  logic        rsp0_v;
  // response buffer 1
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [31:0] rsp1_out;
  logic        rsp1_z;
  logic        rsp1_n;
  logic        rsp1_v;
  // shared ALU
  logic [3:0]  alu_aluop;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic        alu_z;
  logic        alu_n;
  logic        alu_v;

  modport slave (
    input  req0_valid, req0_aluop, req0_a, req0_b,
    input  req1_valid, req1_aluop, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_out, rsp0_z, rsp0_n, rsp0_v,
    output rsp1_valid, rsp1_out, rsp1_z, rsp1_n, rsp1_v,
    input  rsp0_ready, rsp1_ready,
    output alu_aluop, alu_a, alu_b,
    input  alu_out, alu_z, alu_n, alu_v
  );

  modport master (
    output req0_valid, req0_aluop, req0_a, req0_b,
    output req1_valid, req1_aluop, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_out, rsp0_z, rsp0_n, rsp0_v,
    input  rsp1_valid, rsp1_out, rsp1_z, rsp1_n, rsp1_v,
    output rsp0_ready, rsp1_ready,
    input  alu_aluop, alu_a, alu_b,
    output alu_out, alu_z, alu_n, alu_v
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Each requester owns a one-entry response buffer (EMPTY/FULL); a FULL
// buffer being drained this cycle may be refilled at the same edge.
// Build option: define ALU_ARB_RR_EN for round-robin arbitration;
// otherwise requester 0 has fixed priority and no pointer state exists.
module alu_arbiter #(
  parameter int unsigned NREQ = 2
) (
  input logic           CLK,
  input logic           RST,
  alu_arbiter_if.slave  bus
);

  localparam logic [0:0] BUF_EMPTY = 1'b0;
  localparam logic [0:0] BUF_FULL  = 1'b1;

  // buffer state and payload, payload packed as {v, n, z, out}
  logic [0:0]  buf0_q, buf0_d;
  logic [0:0]  buf1_q, buf1_d;
  logic [34:0] data0_q, data0_d;
  logic [34:0] data1_q, data1_d;

  logic [NREQ-1:0] drain;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] grant;

  // eligibility: valid request and a buffer that is empty or draining now
  always_comb begin
    drain    = '0;
    elig     = '0;
    drain[0] = (buf0_q == BUF_FULL) && bus.rsp0_ready;
    drain[1] = (buf1_q == BUF_FULL) && bus.rsp1_ready;
    elig[0]  = bus.req0_valid && ((buf0_q == BUF_EMPTY) || drain[0]);
    elig[1]  = bus.req1_valid && ((buf1_q == BUF_EMPTY) || drain[1]);
  end

`ifdef ALU_ARB_RR_EN
  logic ptr_q, ptr_d;

  // round-robin grant: pointer breaks ties, lone eligible requester wins
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    if (!RST) begin
      if (elig[0] && elig[1]) begin
        grant[ptr_q] = 1'b1;
      end else begin
        grant = elig;
      end
    end
    if (grant[0]) begin
      ptr_d = 1'b1;
    end else if (grant[1]) begin
      ptr_d = 1'b0;
    end
  end

  // pointer register, returns to requester 0 on reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // fixed-priority grant: requester 0 always wins
  always_comb begin
    grant = '0;
    if (!RST) begin
      grant[0] = elig[0];
      grant[1] = elig[1] && !elig[0];
    end
  end
`endif

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];

  // ALU operand mux: granted requester, requester 0 when idle
  always_comb begin
    bus.alu_aluop = bus.req0_aluop;
    bus.alu_a     = bus.req0_a;
    bus.alu_b     = bus.req0_b;
    if (grant[1]) begin
      bus.alu_aluop = bus.req1_aluop;
      bus.alu_a     = bus.req1_a;
      bus.alu_b     = bus.req1_b;
    end
  end

  // buffer next state: refill on grant has precedence over drain
  always_comb begin
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    data0_d = data0_q;
    data1_d = data1_q;
    if (grant[0]) begin
      buf0_d  = BUF_FULL;
      data0_d = {bus.alu_v, bus.alu_n, bus.alu_z, bus.alu_out};
    end else if (drain[0]) begin
      buf0_d  = BUF_EMPTY;
    end
    if (grant[1]) begin
      buf1_d  = BUF_FULL;
      data1_d = {bus.alu_v, bus.alu_n, bus.alu_z, bus.alu_out};
    end else if (drain[1]) begin
      buf1_d  = BUF_EMPTY;
    end
  end

  // response buffer registers, cleared on reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      buf0_q  <= BUF_EMPTY;
      buf1_q  <= BUF_EMPTY;
      data0_q <= '0;
      data1_q <= '0;
    end else begin
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
    end
  end

  assign bus.rsp0_valid = (buf0_q == BUF_FULL);
  assign bus.rsp0_out   = data0_q[31:0];
  assign bus.rsp0_z     = data0_q[32];
  assign bus.rsp0_n     = data0_q[33];
  assign bus.rsp0_v     = data0_q[34];
  assign bus.rsp1_valid = (buf1_q == BUF_FULL);
  assign bus.rsp1_out   = data1_q[31:0];
  assign bus.rsp1_z     = data1_q[32];
  assign bus.rsp1_n     = data1_q[33];
  assign bus.rsp1_v     = data1_q[34];

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU on the shared port.
module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLT = 4'd5;

  typedef struct packed {
    bit          v;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    bit          rr;
  } req_t;

  logic CLK;
  logic RST;
  alu_arbiter_if bus ();

  alu_arbiter #(.NREQ(2)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [34:0] exp0[$];
  logic [34:0] exp1[$];
  bit full0, full1, ptr;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // result packed as {v, n, z, out}
  function automatic logic [34:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] o;
    logic        v;
    v = 1'b0;
    case (op)
      OP_ADD: begin o = a + b; v = (a[31] == b[31]) && (o[31] != a[31]); end
      OP_SUB: begin o = a - b; v = (a[31] != b[31]) && (o[31] != a[31]); end
      OP_AND: o = a & b;
      OP_OR:  o = a | b;
      OP_XOR: o = a ^ b;
      OP_SLT: o = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: o = a;
    endcase
    return {v, o[31], (o == 32'd0), o};
  endfunction

  // shared ALU seen by the arbiter
  always_comb begin
    logic [34:0] r;
    r = alu_ref(bus.alu_aluop, bus.alu_a, bus.alu_b);
    bus.alu_out = r[31:0];
    bus.alu_z   = r[32];
    bus.alu_n   = r[33];
    bus.alu_v   = r[34];
  end

  task automatic chk(input string nm, input logic [34:0] act, input logic [34:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic req_t mk(input bit v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit rr);
    req_t r;
    r.v = v; r.op = op; r.a = a; r.b = b; r.rr = rr;
    return r;
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h7FFFFFFF;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  // one cycle: drive, predict grants at negedge, update model, advance
  task automatic step(input bit rst, input req_t r0, input req_t r1);
    bit e0, e1, g0, g1;
    RST            = rst;
    bus.req0_valid = r0.v;  bus.req0_aluop = r0.op; bus.req0_a = r0.a; bus.req0_b = r0.b;
    bus.rsp0_ready = r0.rr;
    bus.req1_valid = r1.v;  bus.req1_aluop = r1.op; bus.req1_a = r1.a; bus.req1_b = r1.b;
    bus.rsp1_ready = r1.rr;
    @(negedge CLK);
    e0 = !rst && r0.v && (!full0 || r0.rr);
    e1 = !rst && r1.v && (!full1 || r1.rr);
`ifdef ALU_ARB_RR_EN
    g0 = e0 && (!e1 || ptr == 1'b0);
    g1 = e1 && (!e0 || ptr == 1'b1);
`else
    g0 = e0;
    g1 = e1 && !e0;
`endif
    chk("req0_ready", {34'd0, bus.req0_ready}, {34'd0, g0});
    chk("req1_ready", {34'd0, bus.req1_ready}, {34'd0, g1});
    chk("rsp0_valid", {34'd0, bus.rsp0_valid}, {34'd0, full0});
    chk("rsp1_valid", {34'd0, bus.rsp1_valid}, {34'd0, full1});
    if (rst) begin
      exp0.delete();
      exp1.delete();
      full0 = 1'b0;
      full1 = 1'b0;
      ptr   = 1'b0;
    end else begin
      if (g0) exp0.push_back(alu_ref(r0.op, r0.a, r0.b));
      if (g1) exp1.push_back(alu_ref(r1.op, r1.a, r1.b));
      full0 = g0 ? 1'b1 : ((full0 && r0.rr) ? 1'b0 : full0);
      full1 = g1 ? 1'b1 : ((full1 && r1.rr) ? 1'b0 : full1);
      if (g0) ptr = 1'b1;
      else if (g1) ptr = 1'b0;
    end
    @(posedge CLK);
    #1;
  endtask

  // monitor: compare every presented response against the queue head
  always @(negedge CLK) begin
    if (!RST) begin
      if (bus.rsp0_valid) begin
        if (exp0.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp0_spurious actual=%h required=none", bus.rsp0_out);
        end else begin
          chk("rsp0_data", {bus.rsp0_v, bus.rsp0_n, bus.rsp0_z, bus.rsp0_out}, exp0[0]);
          if (bus.rsp0_ready) void'(exp0.pop_front());
        end
      end
      if (bus.rsp1_valid) begin
        if (exp1.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp1_spurious actual=%h required=none", bus.rsp1_out);
        end else begin
          chk("rsp1_data", {bus.rsp1_v, bus.rsp1_n, bus.rsp1_z, bus.rsp1_out}, exp1[0]);
          if (bus.rsp1_ready) void'(exp1.pop_front());
        end
      end
    end
  end

  initial begin
    req_t idle, idle_rr, a, b;
    idle    = mk(0, OP_ADD, 32'd0, 32'd0, 0);
    idle_rr = mk(0, OP_ADD, 32'd0, 32'd0, 1);
    full0 = 0; full1 = 0; ptr = 0;
    RST = 1'b1;
    bus.req0_valid = 0; bus.req0_aluop = '0; bus.req0_a = '0; bus.req0_b = '0; bus.rsp0_ready = 0;
    bus.req1_valid = 0; bus.req1_aluop = '0; bus.req1_a = '0; bus.req1_b = '0; bus.rsp1_ready = 0;
    repeat (2) @(posedge CLK);
    #1;
    // reset cycle with requests pending: no ready
    step(1, mk(1, OP_ADD, 32'd1, 32'd1, 1), mk(1, OP_ADD, 32'd2, 32'd2, 1));
    chk("reset_rsp0", {bus.rsp0_v, bus.rsp0_n, bus.rsp0_z, bus.rsp0_out}, 35'd0);
    chk("reset_rsp1", {bus.rsp1_v, bus.rsp1_n, bus.rsp1_z, bus.rsp1_out}, 35'd0);

    // single issue and overflow
    step(0, mk(1, OP_ADD, 32'd5, 32'd7, 1), idle_rr);
    step(0, idle_rr, idle_rr);
    step(0, idle_rr, mk(1, OP_ADD, 32'h7FFFFFFF, 32'd1, 1));
    step(0, idle_rr, idle_rr);

    // contention, responses always consumed
    for (int i = 0; i < 8; i++)
      step(0, mk(1, OP_ADD, i, 32'd100, 1), mk(1, OP_SUB, i, 32'd100, 1));
    step(0, idle_rr, idle_rr);
    step(0, idle_rr, idle_rr);

    // backpressure then pass-through drain
    step(0, mk(1, OP_ADD, 32'd1, 32'd2, 0), idle);
    step(0, mk(1, OP_SUB, 32'd9, 32'd9, 0), idle);
    step(0, mk(1, OP_SUB, 32'd9, 32'd9, 0), idle);
    step(0, mk(1, OP_SUB, 32'd9, 32'd9, 1), idle);
    step(0, idle_rr, idle_rr);

    // reset mid-operation, then pointer back at requester 0
    step(0, mk(1, OP_SLT, 32'hFFFFFFFF, 32'd0, 0), idle);
    step(1, idle, idle);
    chk("midrst_rsp0", {bus.rsp0_valid, bus.rsp0_v, bus.rsp0_n, bus.rsp0_z, bus.rsp0_out}, 36'd0);
    step(0, mk(1, OP_AND, 32'hF0F0, 32'hFF00, 1), mk(1, OP_OR, 32'h1, 32'h2, 1));
    step(0, idle_rr, idle_rr);
    step(0, idle_rr, idle_rr);

    // randomized traffic including unknown opcodes
    for (int i = 0; i < 400; i++) begin
      a = mk($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), rand_opnd(), rand_opnd(), $urandom_range(0, 3) != 0);
      b = mk($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), rand_opnd(), rand_opnd(), $urandom_range(0, 3) != 0);
      step(0, a, b);
    end
    repeat (4) step(0, idle_rr, idle_rr);
    chk("scoreboard_empty", 35'(exp0.size() + exp1.size()), 35'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: NREQ, 2, number of requesters (fixed at 2; other values unsupported).
REQ-002 CLK  in  1  clock; all state updates on rising edge.
REQ-003 RST  in  1  synchronous, active-high reset.
REQ-004 reqN_valid  in  1  requester N (N=0,1) presents an operation.
REQ-005 reqN_ready  out  1  arbiter accepts requester N operation this cycle.
REQ-006 reqN_aluop  in  4  ALU opcode (cpu_types_pkg aluop_t encoding).
REQ-007 reqN_a, reqN_b  in  32  operands.
REQ-008 rspN_valid  out  1  result for requester N held in response buffer.
REQ-009 rspN_ready  in  1  requester N consumes its result this cycle.
REQ-010 rspN_out  out  32; rspN_z, rspN_n, rspN_v  out  1 each: buffered ALU out/Z/N/V.
REQ-011 alu_aluop  out  4; alu_a, alu_b  out  32: drive to the shared ALU.
REQ-012 alu_out  in  32; alu_z, alu_n, alu_v  in  1: combinational ALU results.

Function
REQ-013 One ALU shared; at most one operation issued per cycle.
REQ-014 Each requester owns a one-entry response buffer, state EMPTY or FULL.
REQ-015 Requester N eligible when reqN_valid=1 and its buffer is EMPTY, or FULL with rspN_valid=1 and rspN_ready=1 the same cycle (pass-through drain).
REQ-016 Grant selects one eligible requester per cycle per the arbitration policy (REQ-027/028); reqN_ready=1 only for the granted requester, combinationally.
REQ-017 alu_aluop/alu_a/alu_b mux the granted requester's inputs; with no grant they drive requester 0 inputs (value don't-care, no state effect).
REQ-018 Handshake fires when reqN_valid=1 and reqN_ready=1; at that edge alu_out/z/n/v latch into buffer N, buffer becomes FULL.
REQ-019 Latency: rspN_valid rises exactly one cycle after the accepting edge; no combinational path from reqN_* to rspN_*.
REQ-020 rspN_valid=1 and rspN_out/z/n/v hold stable until rspN_ready=1; buffer goes EMPTY at that edge unless refilled the same edge (REQ-015), in which case it stays FULL with new data.
REQ-021 reqN_ready independent of reqN_valid of the same requester only via eligibility; reqN_ready=0 while buffer FULL and not draining.
REQ-022 Requester may drop or change reqN_* while reqN_ready=0; no operation is lost or duplicated.
REQ-023 Simultaneous drain of requester 0 and issue for requester 1 permitted in one cycle.
REQ-024 Unrecognized opcodes pass through unchanged; the arbiter does not decode aluop.

Reset
REQ-025 While RST=1 at a rising edge: both buffers EMPTY, rspN_valid=0, rspN_out=0, rspN_z=0, rspN_n=0, rspN_v=0, round-robin pointer points to requester 0; reqN_ready=0 throughout the reset cycle.
REQ-026 RST asserted mid-operation discards any buffered results; an operation handshaking in the same cycle as RST is dropped.

Configuration
REQ-027 With ALU_ARB_RR_EN defined: round-robin; pointer names preferred requester, after any grant pointer moves to the other requester; preferred wins ties; a lone eligible requester always wins.
REQ-028 Without ALU_ARB_RR_EN: fixed priority, requester 0 always wins ties; no pointer state exists.

Verification
REQ-029 Single issue: req0 ADD a=5 b=7 -> req0_ready=1 same cycle; next cycle rsp0_valid=1, rsp0_out=12, z=0, n=0, v=0.
REQ-030 Overflow flag: req1 ADD a=0x7FFFFFFF b=1 -> rsp1_out=0x80000000, n=1, v=1 one cycle later.
REQ-031 Contention, RR build: both requesters valid every cycle, rsp_ready=1 always -> grants alternate 0,1,0,1; fixed-priority build -> requester 0 granted every cycle, requester 1 starved.
REQ-032 Backpressure: rsp0_ready=0 with rsp0 FULL, req0 SUB a=9 b=9 valid -> req0_ready=0, rsp0_out holds old value; raise rsp0_ready -> same cycle req0_ready=1, next cycle rsp0_out=0, z=1.
REQ-033 Reset mid-op: accept req0 SLT a=-1 b=0, assert RST next cycle -> rsp0_valid=0, rsp0_out=0 after reset edge; pointer back to 0.
